// File: rtl/tinytpu_pkg.sv
// tinytpu shared types and width helpers.
// Used by the serial MMU and its MAC cells.
package tinytpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    DRAIN
  } state_t;

  localparam int DEF_D_W       = 8;
  localparam int DEF_N         = 2;
  localparam int DEF_ACC_GUARD = 3;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int acc_w(
    input int d_w,
    input int n,
    input int guard
  );
    return 2 * d_w + clog2(n) + guard;
  endfunction

  localparam int DEF_ACC_W =
    acc_w(DEF_D_W, DEF_N, DEF_ACC_GUARD);

endpackage

// File: rtl/tinytpu_mac_cell.sv
// One multiply-accumulate cell of the tinytpu array.
// Holds a single ACC_W accumulator.
module tinytpu_mac_cell
  import tinytpu_pkg::*;
#(
  parameter int D_W    = DEF_D_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             clear_add,
  input  logic [D_W-1:0]   a,
  input  logic [D_W-1:0]   b,
  output logic [ACC_W-1:0] acc
);

  logic             sa;
  logic             sb;
  logic             sp;
  logic [2*D_W-1:0] xa;
  logic [2*D_W-1:0] xb;
  logic [2*D_W-1:0] prod;
  logic [ACC_W-1:0] addend;
  logic [ACC_W-1:0] base;

  // low 2*D_W bits of the widened product are
  // exact for both signed and unsigned operands
  assign sa = (SIGNED != 0) & a[D_W-1];
  assign sb = (SIGNED != 0) & b[D_W-1];
  assign xa = {{D_W{sa}}, a};
  assign xb = {{D_W{sb}}, b};
  assign prod = xa * xb;
  assign sp = (SIGNED != 0) & prod[2*D_W-1];
  assign addend = {{(ACC_W-2*D_W){sp}}, prod};
  assign base = clear_add ? '0 : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc <= '0;
    else if (clr)
      acc <= '0;
    else if (en)
      acc <= base + addend;
  end

endmodule

// File: rtl/tinytpu_serial_mmu.sv
// Bit-serial N x N matrix multiply engine.
// Serial X/Y load, parallel MAC, handshaked Z drain.
module tinytpu_serial_mmu
  import tinytpu_pkg::*;
#(
  parameter int D_W       = DEF_D_W,
  parameter int N         = DEF_N,
  parameter int SIGNED    = 1,
  parameter int ACC_GUARD = DEF_ACC_GUARD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x_in,
  input  logic y_in,
  input  logic load_en,
  input  logic init,
  input  logic acc_mode,
  output logic z_out,
  output logic z_valid,
  input  logic z_ready,
  output logic busy,
  output logic done
);

  localparam int ACC_W = acc_w(D_W, N, ACC_GUARD);
  localparam int L     = N * N * D_W;
  localparam int M     = N * N * ACC_W;
  localparam int CW    = clog2(M + 1);
  localparam int KW    = clog2(N);

  localparam logic [CW-1:0] L_LAST = CW'(L - 1);
  localparam logic [CW-1:0] K_LAST = CW'(N - 1);
  localparam logic [CW-1:0] M_LAST = CW'(M - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [L-1:0]     x_sr;
  logic [L-1:0]     y_sr;
  logic             acc_mode_q;
  logic             shift_en;
  logic             load_last;
  logic             k_last;
  logic             z_acc;
  logic             z_last;
  logic             cell_en;
  logic             clear_add;
  logic [KW-1:0]    k;
  logic [M-1:0]     z_flat;
  logic [D_W-1:0]   x_el  [N][N];
  logic [D_W-1:0]   y_el  [N][N];
  logic [ACC_W-1:0] acc_q [N][N];

  assign shift_en  = load_en &&
                     (state == IDLE || state == LOAD);
  assign load_last = state == LOAD && load_en &&
                     cnt == L_LAST;
  assign k_last    = state == COMPUTE && cnt == K_LAST;
  assign z_acc     = state == DRAIN && z_ready;
  assign z_last    = z_acc && cnt == M_LAST;
  assign cell_en   = state == COMPUTE && !init;
  assign clear_add = cnt == '0 && !acc_mode_q;
  assign k         = cnt[KW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_en) state_nxt = LOAD;
      LOAD:    if (load_last) state_nxt = COMPUTE;
      COMPUTE: if (k_last) state_nxt = DRAIN;
      DRAIN:   if (z_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (init) state_nxt = IDLE;
  end

  always_comb begin
    z_valid = state == DRAIN;
    busy    = state != IDLE;
    done    = z_last && !init;
    z_out   = 1'b0;
    if (state == DRAIN) z_out = z_flat[M_LAST - cnt];
  end

  // one counter serves load bits, k, and drain bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      x_sr       <= '0;
      y_sr       <= '0;
      acc_mode_q <= 1'b0;
    end else if (init) begin
      cnt        <= '0;
      x_sr       <= '0;
      y_sr       <= '0;
      acc_mode_q <= 1'b0;
    end else begin
      if (shift_en) begin
        x_sr <= {x_sr[L-2:0], x_in};
        y_sr <= {y_sr[L-2:0], y_in};
      end
      if (load_last) acc_mode_q <= acc_mode;
      if (load_last || k_last || z_last)
        cnt <= '0;
      else if (shift_en || state == COMPUTE || z_acc)
        cnt <= cnt + CW'(1);
    end
  end

  for (genvar e = 0; e < N * N; e++) begin : g_el
    assign x_el[e/N][e%N] = x_sr[L-1-e*D_W -: D_W];
    assign y_el[e/N][e%N] = y_sr[L-1-e*D_W -: D_W];
    assign z_flat[M-1-e*ACC_W -: ACC_W] =
      acc_q[e/N][e%N];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      tinytpu_mac_cell #(
        .D_W    (D_W),
        .ACC_W  (ACC_W),
        .SIGNED (SIGNED)
      ) u_cell (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (init),
        .en        (cell_en),
        .clear_add (clear_add),
        .a         (x_el[i][k]),
        .b         (y_el[k][j]),
        .acc       (acc_q[i][j])
      );
    end
  end

endmodule

// File: tb/tb_tinytpu_serial_mmu.sv
// Directed bench for tinytpu_serial_mmu, N=2 D_W=8.
// Signed and unsigned instances share all inputs.
module tb_tinytpu_serial_mmu;

  logic clk;
  logic rst_n;
  logic x_in;
  logic y_in;
  logic load_en;
  logic init;
  logic acc_mode;
  logic z_ready;
  logic z_out;
  logic z_valid;
  logic busy;
  logic done;
  logic z_out_u;
  logic z_valid_u;
  logic busy_u;
  logic done_u;

  int n_chk;
  int n_fail;

  localparam logic [31:0] XB = {8'd1, 8'd2, 8'd3, 8'd4};
  localparam logic [31:0] YB = {8'd5, 8'd6, 8'd7, 8'd8};
  localparam logic [79:0] ZB =
    {20'd19, 20'd22, 20'd43, 20'd50};
  localparam logic [79:0] ZA =
    {20'd38, 20'd44, 20'd86, 20'd100};
  localparam logic [31:0] XS =
    {8'h80, 8'h00, 8'h00, 8'h80};
  localparam logic [31:0] YS =
    {8'h80, 8'h7F, 8'h7F, 8'h80};
  localparam logic [79:0] ZS =
    {20'd16384, 20'hFC080, 20'hFC080, 20'd16384};
  localparam logic [79:0] ZU =
    {20'd16384, 20'd16256, 20'd16256, 20'd16384};

  tinytpu_serial_mmu #(
    .D_W(8), .N(2), .SIGNED(1), .ACC_GUARD(3)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x_in     (x_in),
    .y_in     (y_in),
    .load_en  (load_en),
    .init     (init),
    .acc_mode (acc_mode),
    .z_out    (z_out),
    .z_valid  (z_valid),
    .z_ready  (z_ready),
    .busy     (busy),
    .done     (done)
  );

  tinytpu_serial_mmu #(
    .D_W(8), .N(2), .SIGNED(0), .ACC_GUARD(3)
  ) u_dut_u (
    .clk      (clk),
    .rst_n    (rst_n),
    .x_in     (x_in),
    .y_in     (y_in),
    .load_en  (load_en),
    .init     (init),
    .acc_mode (acc_mode),
    .z_out    (z_out_u),
    .z_valid  (z_valid_u),
    .z_ready  (z_ready),
    .busy     (busy_u),
    .done     (done_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load(
    input logic [31:0] xv,
    input logic [31:0] yv,
    input logic        am,
    input int          pause_at
  );
    acc_mode = am;
    for (int b = 0; b < 32; b++) begin
      if (b == pause_at)
        repeat (5) begin
          @(negedge clk);
          load_en = 1'b0;
        end
      @(negedge clk);
      x_in    = xv[31-b];
      y_in    = yv[31-b];
      load_en = 1'b1;
    end
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic drain(
    input  bit          tog,
    output logic [79:0] zv,
    output logic [79:0] zu,
    output int          lat,
    output int          cyc,
    output int          nacc,
    output int          ndone,
    output bit          done_bad,
    output bit          unstable
  );
    bit   held;
    logic prev_z;
    zv = '0; zu = '0;
    lat = 0; cyc = 0; nacc = 0; ndone = 0;
    done_bad = 0; unstable = 0;
    held = 0; prev_z = 0;
    while (!z_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    while (z_valid && cyc < 400) begin
      z_ready = tog ? (cyc % 3 != 1) : 1'b1;
      #1;
      if (held && z_out !== prev_z) unstable = 1;
      if (done === 1'b1) ndone++;
      if (done !== (z_ready && nacc == 79))
        done_bad = 1;
      if (z_ready && nacc < 80) begin
        zv[79-nacc] = z_out;
        zu[79-nacc] = z_out_u;
        nacc++;
      end
      held   = !z_ready;
      prev_z = z_out;
      cyc++;
      @(negedge clk);
    end
    z_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 0; x_in = 0; y_in = 0; load_en = 0;
    init = 0; acc_mode = 0; z_ready = 0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({z_out, z_valid, busy, done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_out: got %b want 0000",
               {z_out, z_valid, busy, done});
    end
    n_chk++;
    if ({z_out_u, z_valid_u, busy_u, done_u} !== 4'b0)
    begin
      n_fail++;
      $display("FAIL reset_out_u: got %b want 0000",
               {z_out_u, z_valid_u, busy_u, done_u});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [79:0] zv, zu;
    int lat, cyc, nacc, nd;
    bit db, us;
    load(XB, YB, 1'b0, -1);
    n_chk++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    drain(0, zv, zu, lat, cyc, nacc, nd, db, us);
    n_chk++;
    if (lat !== 2) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d want 2", lat);
    end
    n_chk++;
    if (zv !== ZB) begin
      n_fail++;
      $display("FAIL basic_z: got %h want %h", zv, ZB);
    end
    n_chk++;
    if (cyc !== 80 || nacc !== 80) begin
      n_fail++;
      $display("FAIL basic_cycles: got %0d/%0d want 80",
               cyc, nacc);
    end
    n_chk++;
    if (nd !== 1 || db) begin
      n_fail++;
      $display("FAIL basic_done: got %0d bad=%0d want 1",
               nd, db);
    end
    n_chk++;
    if (busy !== 1'b0 || z_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_idle: got %b%b want 00",
               busy, z_valid);
    end
  endtask

  task automatic test_accumulate;
    logic [79:0] zv, zu;
    int lat, cyc, nacc, nd;
    bit db, us;
    load(XB, YB, 1'b1, -1);
    drain(0, zv, zu, lat, cyc, nacc, nd, db, us);
    n_chk++;
    if (zv !== ZA) begin
      n_fail++;
      $display("FAIL acc_z: got %h want %h", zv, ZA);
    end
    load(XB, YB, 1'b0, -1);
    drain(0, zv, zu, lat, cyc, nacc, nd, db, us);
    n_chk++;
    if (zv !== ZB) begin
      n_fail++;
      $display("FAIL overwrite_z: got %h want %h", zv, ZB);
    end
  endtask

  task automatic test_signed;
    logic [79:0] zv, zu;
    int lat, cyc, nacc, nd;
    bit db, us;
    load(XS, YS, 1'b0, -1);
    drain(0, zv, zu, lat, cyc, nacc, nd, db, us);
    n_chk++;
    if (zv !== ZS) begin
      n_fail++;
      $display("FAIL signed_z: got %h want %h", zv, ZS);
    end
    n_chk++;
    if (zu !== ZU) begin
      n_fail++;
      $display("FAIL unsigned_z: got %h want %h", zu, ZU);
    end
  endtask

  task automatic test_load_pause;
    logic [79:0] zv, zu;
    int lat, cyc, nacc, nd;
    bit db, us;
    load(XB, YB, 1'b0, 12);
    drain(0, zv, zu, lat, cyc, nacc, nd, db, us);
    n_chk++;
    if (zv !== ZB) begin
      n_fail++;
      $display("FAIL pause_z: got %h want %h", zv, ZB);
    end
  endtask

  task automatic test_z_ready_toggle;
    logic [79:0] zv, zu;
    int lat, cyc, nacc, nd;
    bit db, us;
    load(XB, YB, 1'b0, -1);
    drain(1, zv, zu, lat, cyc, nacc, nd, db, us);
    n_chk++;
    if (zv !== ZB) begin
      n_fail++;
      $display("FAIL toggle_z: got %h want %h", zv, ZB);
    end
    n_chk++;
    if (us) begin
      n_fail++;
      $display("FAIL toggle_stable: got unstable want stable");
    end
    n_chk++;
    if (nd !== 1 || db || nacc !== 80) begin
      n_fail++;
      $display("FAIL toggle_done: got %0d bad=%0d n=%0d want 1",
               nd, db, nacc);
    end
  endtask

  task automatic test_init_abort;
    logic [79:0] zv, zu;
    int lat, cyc, nacc, nd;
    bit db, us;
    acc_mode = 1'b0;
    for (int b = 0; b < 17; b++) begin
      @(negedge clk);
      x_in = XB[31-b]; y_in = YB[31-b]; load_en = 1'b1;
    end
    @(negedge clk);
    x_in = XB[14]; y_in = YB[14];
    init = 1'b1;
    #1;
    n_chk++;
    if (done !== 1'b0) begin
      n_fail++;
      $display("FAIL init_done: got %b want 0", done);
    end
    @(negedge clk);
    init = 1'b0; load_en = 1'b0;
    #1;
    n_chk++;
    if (busy !== 1'b0 || z_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL init_idle: got %b%b want 00",
               busy, z_valid);
    end
    load(XB, YB, 1'b1, -1);
    drain(0, zv, zu, lat, cyc, nacc, nd, db, us);
    n_chk++;
    if (zv !== ZB) begin
      n_fail++;
      $display("FAIL init_reload_z: got %h want %h", zv, ZB);
    end
  endtask

  task automatic test_reset_drain;
    logic [79:0] zv, zu;
    int lat, cyc, nacc, nd, w;
    bit db, us;
    load(XB, YB, 1'b0, -1);
    w = 0;
    while (!z_valid && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_chk++;
    if (w >= 50) begin
      n_fail++;
      $display("FAIL rst_wait: got timeout want z_valid");
    end
    z_ready = 1'b1;
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (z_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: got %b%b want 00",
               z_valid, busy);
    end
    z_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    load(XB, YB, 1'b1, -1);
    drain(0, zv, zu, lat, cyc, nacc, nd, db, us);
    n_chk++;
    if (zv !== ZB) begin
      n_fail++;
      $display("FAIL rst_reload_z: got %h want %h", zv, ZB);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset;
    test_basic;
    test_accumulate;
    test_signed;
    test_load_pause;
    test_z_ready_toggle;
    test_init_abort;
    test_reset_drain;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
